// File: rtl/rv_mem_pkg.sv
// Shared encodings and helpers for the RV052B data-memory load/store unit.
// Holds request encodings, FSM states and lane steering/extraction functions.
package rv_mem_pkg;

    localparam logic [1:0] MEM_LOAD  = 2'b00;
    localparam logic [1:0] MEM_STORE = 2'b01;

    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b010;
    localparam logic [2:0] W_W  = 3'b100;
    localparam logic [2:0] W_BU = 3'b001;
    localparam logic [2:0] W_HU = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } mem_state_e;

    // Unknown op, unknown width, or an unsigned width used by a store.
    function automatic logic req_illegal(
        input logic [1:0] op,
        input logic [2:0] w
    );
        logic bad_op;
        logic bad_w;
        logic bad_st;
        bad_op = (op != MEM_LOAD) && (op != MEM_STORE);
        bad_w  = (w != W_B) && (w != W_H) && (w != W_W)
              && (w != W_BU) && (w != W_HU);
        bad_st = (op == MEM_STORE) && ((w == W_BU) || (w == W_HU));
        return bad_op || bad_w || bad_st;
    endfunction

    function automatic logic req_misaligned(
        input logic [2:0] w,
        input logic [1:0] a
    );
        logic is_h;
        is_h = (w == W_H) || (w == W_HU);
        return (is_h && a[0]) || ((w == W_W) && (a != 2'b00));
    endfunction

    function automatic logic [3:0] store_be(
        input logic [2:0] w,
        input logic [1:0] a
    );
        logic [3:0] be;
        unique case (1'b1)
            (w == W_B): be = 4'b0001 << a;
            (w == W_H): be = a[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

    // Narrow data is replicated so every enabled lane sees its bytes.
    function automatic logic [31:0] store_data(
        input logic [2:0]  w,
        input logic [31:0] d
    );
        logic [31:0] r;
        unique case (1'b1)
            (w == W_B): r = {4{d[7:0]}};
            (w == W_H): r = {2{d[15:0]}};
            default:    r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(
        input logic [2:0]  w,
        input logic [1:0]  a,
        input logic [31:0] d
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        unique case (1'b1)
            (w == W_B):  r = {{24{b[7]}}, b};
            (w == W_BU): r = {24'h0, b};
            (w == W_H):  r = {{16{h[15]}}, h};
            (w == W_HU): r = {16'h0, h};
            default:     r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Four 8-bit RAM lanes with per-lane write enable and a registered read.
// READ_LAT selects one or two output register stages.
module dmem_bytelane_ram #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] rd1;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] q;

        // lane write when its enable is set; registered read on re
        always_ff @(posedge clk) begin
            if (we && be[l]) begin
                mem[addr] <= wdata[8*l +: 8];
            end
            if (re) begin
                q <= mem[addr];
            end
        end

        assign rd1[8*l +: 8] = q;
    end

    if (READ_LAT == 2) begin : g_lat2
        logic [31:0] rd2;

        // extra output stage for the two-cycle RAM configuration
        always_ff @(posedge clk) begin
            rd2 <= rd1;
        end

        assign rdata = rd2;
    end else begin : g_lat1
        assign rdata = rd1;
    end

endmodule

// File: rtl/data_mem_unit.sv
// Memory-stage load/store unit: address add, lane steering, extraction.
// Start/done handshake with busy stall and error reporting.
module data_mem_unit
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op_mode1,
    input  logic [2:0]  op_mode2,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] imm_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] res
);

    mem_state_e state_q;
    mem_state_e state_d;

    logic [31:0]       ea_in;
    logic              bad_in;
    logic              accept;
    logic [ADDR_W+1:0] ea_q;
    logic [1:0]        op_q;
    logic [2:0]        w_q;
    logic [31:0]       wd_q;
    logic              err_q;
    logic [31:0]       res_q;

    logic              ram_we;
    logic              ram_re;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wd;
    logic [31:0]       ram_rd;
    logic [31:0]       load_val;
    logic              load_ok;
    logic              is_store;
    logic              unused_ea;

    assign ea_in     = op1 + imm_data;
    assign unused_ea = ^ea_in[31:ADDR_W+2];
    assign bad_in    = req_illegal(op_mode1, op_mode2)
                    || req_misaligned(op_mode2, ea_in[1:0]);
    assign accept    = (state_q == S_IDLE) && start;
    assign is_store  = (op_q == MEM_STORE);

    // rst gates the write so a reset in the access cycle leaves RAM intact
    assign ram_we = (state_q == S_ACCESS) && is_store && !rst;
    assign ram_re = (state_q == S_ACCESS) && !is_store;
    assign ram_be = store_be(w_q, ea_q[1:0]);
    assign ram_wd = store_data(w_q, wd_q);

    dmem_bytelane_ram #(
        .ADDR_W   (ADDR_W),
        .READ_LAT (READ_LAT)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .be    (ram_be),
        .addr  (ea_q[ADDR_W+1:2]),
        .wdata (ram_wd),
        .rdata (ram_rd)
    );

    assign load_val = load_ext(w_q, ea_q[1:0], ram_rd);
    assign load_ok  = (state_q == S_RESP) && !is_store && !err_q;

    // state register, request latch and held load result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ea_q    <= '0;
            op_q    <= MEM_LOAD;
            w_q     <= W_W;
            wd_q    <= '0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ea_q  <= ea_in[ADDR_W+1:0];
                op_q  <= op_mode1;
                w_q   <= op_mode2;
                wd_q  <= op2;
                err_q <= bad_in;
            end
            if (load_ok) begin
                res_q <= load_val;
            end
        end
    end

    // next state: errors skip the RAM, stores never wait on read latency
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = bad_in ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (is_store || (READ_LAT == 1)) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_RESP);
    assign err  = done && err_q;
    assign res  = load_ok ? load_val : res_q;

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised data-memory load/store unit for the RV052B core's memory stage, successor to the single-purpose data RAM. It computes the effective byte address and performs byte/half/word stores through per-byte write enables. Loads extract the addressed lane with sign or zero extension, and misaligned or illegal requests are flagged. A start/done handshake and a configurable RAM read latency let the pipeline stall on `busy`.

## Interface
- `ADDR_W`, 10: word-address width; capacity 2^ADDR_W 32-bit words.
- `READ_LAT`, 1: RAM read latency in cycles; legal values are 1 and 2.
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op_mode1`  in  2  operation: 00 load, 01 store; 10/11 illegal.
- `op_mode2`  in  3  width: 000 byte, 010 half, 100 word, 001 byte unsigned (load only), 011 half unsigned (load only); others illegal.
- `op1`  in  32  base register (rs1).
- `op2`  in  32  store data (rs2).
- `imm_data`  in  32  address offset.
- `busy`  out  1  high from the accept cycle +1 until `done`, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: misaligned or illegal request.
- `res`  out  32  load result; updates only on a successful load `done` and is held otherwise.

## Operation
- States: IDLE -> ACCESS -> (WAIT when READ_LAT=2) -> RESP -> IDLE. An error path goes IDLE -> RESP directly.
- Accept: in IDLE with `start`=1, the unit latches `ea = op1 + imm_data` (32-bit, carry dropped), the modes, and `op2`.
- Misaligned: half with ea[0]=1, or word with ea[1:0]!=0.
- Illegal:
  - `op_mode1` is 10 or 11.
  - `op_mode2` is 101, 110 or 111.
  - A store with `op_mode2` of 001 or 011.
- Misaligned or illegal requests make no RAM access. They return `done`=1 and `err`=1, and `res` is unchanged.
- Word index is ea[ADDR_W+1:2]. Upper address bits are ignored, so accesses wrap modulo capacity.
- Store byte enables:
  - Byte: `1<<ea[1:0]`, with op2[7:0] replicated on all lanes.
  - Half: `0011` or `1100` selected by ea[1], with op2[15:0] replicated.
  - Word: `1111`.
- Load extraction: select the lane given by ea[1:0] (byte) or ea[1] (half), then sign-extend, or zero-extend for the U variants.
- `start` while `busy` is ignored, with no queuing.
- RAM contents are not affected by `rst`.

## Timing
- Accept at cycle N.
- Store: RAM write at the edge ending N+1; `done` at N+2.
- Load: read issued at N+1; `done` and `res` valid at N+1+READ_LAT.
- Error: `done`/`err` at N+1.
- Back-to-back: a new `start` is accepted in the cycle after `done`. A load at cycle M that follows a store to the same word returns the new data.
- Reset values: `busy`=0, `done`=0, `err`=0, `res`=0, state IDLE.
- Reset mid-operation: the state returns to IDLE and no `done` is issued. If `rst` is high in cycle N+1, the store write is suppressed.
- `rst` has priority over `start` in the same cycle.

## Structure
- Package `rv_mem_pkg` holds:
  - Constants `MEM_LOAD`/`MEM_STORE`.
  - Width encodings `W_B`, `W_H`, `W_W`, `W_BU`, `W_HU`.
  - The state enum.
- Sub-module `dmem_bytelane_ram`: four 8-bit lanes with per-lane write enable and a READ_LAT output register chain, inferable as block RAM.
- The top level contains the FSM, the address adder, lane steering and extraction.

## Test plan
- Word store then load: op1=0x100, imm=0x4, op2=0xDEADBEEF, SW then LW. Required: `done` at N+2 each time, and `res`=0xDEADBEEF.
- Byte lanes: SB 0x80 to ea=0x105, then LB and LBU at ea=0x105. Required: LB gives 0xFFFFFF80, LBU gives 0x00000080, and LW at 0x104 gives 0xDEAD80EF.
- Half: SH 0x8001 at ea=0x106, then LH and LHU. Required: LH gives 0xFFFF8001, LHU gives 0x00008001.
- Misaligned/illegal:
  - LW at ea=0x102 -> `done`+`err` at N+1, `res` unchanged, RAM untouched.
  - `op_mode1`=10 -> `err`.
- Wrap and READ_LAT=2: with ADDR_W=10, SW to ea=0x1004 aliases ea=0x4. LW at 0x4 returns the stored data with `done` at N+3.
- Reset and busy: assert `rst` at N+1 of an SW -> no write and no `done`. `start` while `busy` -> ignored.
